// File: rtl/riscv_pkg.sv
// Shared RV64 front-end constants and the fetch-queue entry layout.
package riscv_pkg;

   localparam int          XLEN      = 64;
   localparam int          ILEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [63:0] PC_INC    = 64'd4;

   typedef struct packed {
      logic [ILEN-1:0] ir;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; used for the instruction queue and the issued-PC tag FIFO.
module fetch_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       wdata_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: only entries below cnt_q are ever observed.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, fetch queue, redirect flush.
// Optional FE_MISALIGN_TRAP_EN: misaligned redirect target parks on a NOP with FE_EXC set.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [63:0] RESET_PC        = 64'h0,
   parameter int          FQ_DEPTH        = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            FE_PC_MUX,
   input  logic [XLEN-1:0] FE_Target_Address,
   output logic            IMEM_REQ_V,
   input  logic            IMEM_REQ_RDY,
   output logic [XLEN-1:0] IMEM_REQ_ADDR,
   input  logic            IMEM_RESP_V,
   input  logic [ILEN-1:0] IMEM_RESP_DATA,
   output logic            DE_V,
   input  logic            DE_STALL,
   output logic [ILEN-1:0] DE_IR,
   output logic [XLEN-1:0] DE_PC,
   output logic [XLEN-1:0] DE_NPC
`ifdef FE_MISALIGN_TRAP_EN
   ,
   output logic            FE_EXC
`endif
);
   localparam int CW     = $clog2(FQ_DEPTH) + 1;
   localparam int MO_EFF = (MAX_OUTSTANDING > FQ_DEPTH) ? FQ_DEPTH : MAX_OUTSTANDING;
   localparam logic [CW-1:0] MO_LIM    = CW'(MO_EFF);
   localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FQ_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
   logic            run_q;
   logic            trap_q, trap_d;

   logic            hs, iq_push, iq_pop, tg_push;
   logic            iq_full, iq_empty, tg_full, tg_empty;
   logic [CW-1:0]   iq_count, tg_count;
   fq_entry_t       iq_wdata, iq_head;
   logic [XLEN-1:0] tg_head;

   // run_q keeps IMEM_REQ_V low for the cycle in which reset releases.
   always_comb begin
      IMEM_REQ_V = run_q && !FE_PC_MUX && !trap_q && (out_q < MO_LIM) &&
                   (({1'b0, out_q} + {1'b0, iq_count}) < DEPTH_LIM);
   end
   assign IMEM_REQ_ADDR = pc_q;
   assign hs            = IMEM_REQ_V && IMEM_REQ_RDY;
   assign tg_push       = hs && !tg_full;

   // A response landing in a redirect cycle belongs to the old path.
   assign iq_push  = IMEM_RESP_V && (drop_q == '0) && !FE_PC_MUX && !tg_empty;
   assign iq_pop   = !iq_empty && !DE_STALL;
   assign iq_wdata = '{ir: IMEM_RESP_DATA, pc: tg_head};

   always_comb begin
      out_d  = out_q + CW'(hs) - CW'(IMEM_RESP_V);
      drop_d = drop_q;
      if (FE_PC_MUX)
         drop_d = out_d;
      else if (IMEM_RESP_V && (drop_q != '0))
         drop_d = drop_q - CW'(1);
      pc_d   = pc_q;
      trap_d = trap_q;
      if (FE_PC_MUX) begin
`ifdef FE_MISALIGN_TRAP_EN
         pc_d   = FE_Target_Address;
         trap_d = |FE_Target_Address[1:0];
`else
         pc_d   = {FE_Target_Address[XLEN-1:2], 2'b00};
         trap_d = 1'b0;
`endif
      end else if (hs) begin
         pc_d = pc_next(pc_q);
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
         run_q  <= 1'b0;
         trap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         run_q  <= 1'b1;
         trap_q <= trap_d;
      end
   end

   always_comb begin
      DE_V   = 1'b0;
      DE_IR  = '0;
      DE_PC  = '0;
      DE_NPC = '0;
      if (trap_q) begin
         DE_V   = 1'b1;
         DE_IR  = NOP_INSTR;
         DE_PC  = pc_q;
         DE_NPC = pc_next(pc_q);
      end else if (!iq_empty) begin
         DE_V   = 1'b1;
         DE_IR  = iq_head.ir;
         DE_PC  = iq_head.pc;
         DE_NPC = pc_next(iq_head.pc);
      end
   end

`ifdef FE_MISALIGN_TRAP_EN
   assign FE_EXC = trap_q;
   logic unused_ok;
   assign unused_ok = ^{tg_count, iq_full};
`else
   logic unused_ok;
   assign unused_ok = ^{tg_count, iq_full, FE_Target_Address[1:0]};
`endif

   fetch_queue #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_iq (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .push_i  (iq_push),
      .pop_i   (iq_pop),
      .flush_i (FE_PC_MUX),
      .wdata_i (iq_wdata),
      .rdata_o (iq_head),
      .full_o  (iq_full),
      .empty_o (iq_empty),
      .count_o (iq_count)
   );

   fetch_queue #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_tag (
      .clk_i   (CLK),
      .rst_ni  (RESET),
      .push_i  (tg_push),
      .pop_i   (iq_push),
      .flush_i (FE_PC_MUX),
      .wdata_i (pc_q),
      .rdata_o (tg_head),
      .full_o  (tg_full),
      .empty_o (tg_empty),
      .count_o (tg_count)
   );

endmodule
